// File: rtl/spi_ram_pkg.sv
// Shared types and helpers for the SPI command-decoding RAM.
//   cmd_t     : 2-bit command carried in the top bits of each rx word
//   ram_aw    : index width needed to address a DEPTH-word array
//   next_addr : post-increment with wrap to 0 at DEPTH
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  function automatic int unsigned ram_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Any pointer at or beyond DEPTH-1 (including an out-of-range one) wraps to 0.
  function automatic int unsigned next_addr(input int unsigned addr,
                                            input int unsigned depth);
    return ((addr + 1) >= depth) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_p_ram_core.sv
// Single-port-write / registered-read word RAM, no array reset.
//   clk     : clock
//   wr_en   : write strobe, wr_addr/wr_data written at posedge
//   rd_en   : read strobe, rd_data loads mem[rd_addr] at posedge
//   rd_data : registered read data, holds when rd_en is low
// Same-address write and read in one cycle returns the write data.
module ram_core
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = ram_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (wr_en && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/spi_ram_ctrl_p.sv
// Command-decoding RAM behind the SPI slave.
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset (memory contents kept)
//   rx_valid : qualifies din
//   din      : {cmd[1:0], payload[DATA_W-1:0]}
//   dout     : read data, valid while tx_valid is high, held otherwise
//   tx_valid : one-cycle strobe per accepted RD_DATA
//   addr_err : one-cycle strobe when WR_DATA/RD_DATA addresses >= DEPTH
// RD_DATA sampled at edge N: RAM read at N, dout/tx_valid updated at N+1.
module spi_ram_ctrl_p
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AUTO_INC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              addr_err
);

  localparam int unsigned     RAM_AW  = ram_aw(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (ADDR_W > DATA_W) begin : g_err_addr_w
    $error("spi_ram_ctrl_p: ADDR_W (%0d) must not exceed DATA_W (%0d)", ADDR_W, DATA_W);
  end
  if ((DEPTH < 1) || (DEPTH > (1 << ADDR_W))) begin : g_err_depth
    $error("spi_ram_ctrl_p: DEPTH (%0d) must be in 1..2**ADDR_W", DEPTH);
  end

  cmd_t              cmd;
  logic [DATA_W-1:0] payload;
  logic              wr_in_range;
  logic              rd_in_range;

  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_err_q,  rd_err_d;
  logic [DATA_W-1:0] dout_q,    dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              addr_err_q, addr_err_d;

  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rd_data;

  assign cmd         = cmd_t'(din[DATA_W+1:DATA_W]);
  assign payload     = din[DATA_W-1:0];
  assign wr_in_range = ({1'b0, wr_addr_q} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr_q} < DEPTH_L);

  always_comb begin
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_pend_d  = 1'b0;
    rd_err_d   = 1'b0;
    addr_err_d = 1'b0;
    ram_wr_en  = 1'b0;
    ram_rd_en  = 1'b0;
    // Second pipeline stage: present the RAM read (or zero for a bad address).
    tx_valid_d = rd_pend_q;
    dout_d     = dout_q;
    if (rd_pend_q) begin
      dout_d = rd_err_q ? '0 : ram_rd_data;
    end

    if (rx_valid) begin
      case (cmd)
        CMD_WR_ADDR: wr_addr_d = payload[ADDR_W-1:0];
        CMD_WR_DATA: begin
          ram_wr_en  = wr_in_range;
          addr_err_d = !wr_in_range;
          if (AUTO_INC != 0) begin
            wr_addr_d = ADDR_W'(next_addr(32'(wr_addr_q), DEPTH));
          end
        end
        CMD_RD_ADDR: rd_addr_d = payload[ADDR_W-1:0];
        CMD_RD_DATA: begin
          ram_rd_en  = rd_in_range;
          rd_pend_d  = 1'b1;
          rd_err_d   = !rd_in_range;
          addr_err_d = !rd_in_range;
          if (AUTO_INC != 0) begin
            rd_addr_d = ADDR_W'(next_addr(32'(rd_addr_q), DEPTH));
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_pend_q  <= rd_pend_d;
      rd_err_q   <= rd_err_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  ram_core #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ram_wr_en),
    .wr_addr(wr_addr_q[RAM_AW-1:0]),
    .wr_data(payload),
    .rd_en  (ram_rd_en),
    .rd_addr(rd_addr_q[RAM_AW-1:0]),
    .rd_data(ram_rd_data)
  );

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
module tb_spi_ram_ctrl_p;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx   [3];
  logic [9:0] din  [3];
  logic [7:0] dout [3];
  logic       tx   [3];
  logic       err  [3];

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  // 0: default 256-word, no auto-inc
  spi_ram_ctrl_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .AUTO_INC(0)) u_a (
    .clk(clk), .rst(rst), .rx_valid(rx[0]), .din(din[0]),
    .dout(dout[0]), .tx_valid(tx[0]), .addr_err(err[0]));
  // 1: 4-word burst RAM
  spi_ram_ctrl_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .AUTO_INC(1)) u_b (
    .clk(clk), .rst(rst), .rx_valid(rx[1]), .din(din[1]),
    .dout(dout[1]), .tx_valid(tx[1]), .addr_err(err[1]));
  // 2: 200-word RAM with unmapped top of address space
  spi_ram_ctrl_p #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .AUTO_INC(0)) u_c (
    .clk(clk), .rst(rst), .rx_valid(rx[2]), .din(din[2]),
    .dout(dout[2]), .tx_valid(tx[2]), .addr_err(err[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int unsigned idx, input logic [1:0] c, input logic [7:0] p);
    rx[idx]  = 1'b1;
    din[idx] = {c, p};
    tick();
    rx[idx]  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx[i]  = 1'b0;
      din[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_dout%0d", i), dout[i], 8'h00);
      chk($sformatf("rst_tx%0d", i), {7'd0, tx[i]}, 8'h00);
      chk($sformatf("rst_err%0d", i), {7'd0, err[i]}, 8'h00);
    end
    rst = 1'b0;

    // ---- DUT 0: basic path ----
    send(0, CMD_WR_ADDR, 8'h00);  chk("a_wa_tx", {7'd0, tx[0]}, 8'h00);
    send(0, CMD_WR_DATA, 8'h42);  chk("a_wd_tx", {7'd0, tx[0]}, 8'h00);
    send(0, CMD_RD_DATA, 8'h00);  chk("a_rd0_lat", {7'd0, tx[0]}, 8'h00);
    tick();                       chk("a_rd0_tx", {7'd0, tx[0]}, 8'h01);
                                  chk("a_rd0_dout", dout[0], 8'h42);

    send(0, CMD_WR_ADDR, 8'h05);  chk("a_wa5_tx", {7'd0, tx[0]}, 8'h00);
    send(0, CMD_WR_DATA, 8'hA5);  chk("a_wd5_tx", {7'd0, tx[0]}, 8'h00);
    send(0, CMD_RD_ADDR, 8'h05);  chk("a_ra5_tx", {7'd0, tx[0]}, 8'h00);
    chk("a_ra5_dout_hold", dout[0], 8'h42);
    send(0, CMD_RD_DATA, 8'h00);  chk("a_rd5_lat", {7'd0, tx[0]}, 8'h00);
    tick();                       chk("a_rd5_tx", {7'd0, tx[0]}, 8'h01);
                                  chk("a_rd5_dout", dout[0], 8'hA5);
    tick();                       chk("a_rd5_tx_end", {7'd0, tx[0]}, 8'h00);
                                  chk("a_rd5_dout_hold", dout[0], 8'hA5);

    // rx_valid low: commands on din must be ignored
    for (int i = 0; i < 10; i++) begin
      rx[0]  = 1'b0;
      din[0] = (i < 5) ? 10'h300 : 10'h009;
      tick();
      chk($sformatf("a_idle_tx%0d", i), {7'd0, tx[0]}, 8'h00);
    end
    send(0, CMD_RD_DATA, 8'h00);
    tick();                       chk("a_idle_rdaddr", dout[0], 8'hA5);
    send(0, CMD_WR_DATA, 8'h3C);
    send(0, CMD_RD_DATA, 8'h00);
    tick();                       chk("a_idle_wraddr", dout[0], 8'h3C);

    // Write then immediately read the same address
    send(0, CMD_WR_DATA, 8'hA5);
    send(0, CMD_RD_DATA, 8'h00);
    tick();                       chk("a_wr_rd_tx", {7'd0, tx[0]}, 8'h01);
                                  chk("a_wr_rd_dout", dout[0], 8'hA5);

    // Back-to-back reads: two strobes on consecutive cycles
    rx[0] = 1'b1; din[0] = {CMD_RD_DATA, 8'h00};
    tick();                       chk("a_b2b_lat", {7'd0, tx[0]}, 8'h00);
    tick();                       rx[0] = 1'b0;
                                  chk("a_b2b_tx1", {7'd0, tx[0]}, 8'h01);
    tick();                       chk("a_b2b_tx2", {7'd0, tx[0]}, 8'h01);
                                  chk("a_b2b_dout2", dout[0], 8'hA5);
    tick();                       chk("a_b2b_tx3", {7'd0, tx[0]}, 8'h00);

    // Reset right after a read is sampled suppresses the strobe
    send(0, CMD_RD_DATA, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;                   chk("a_rstmid_tx", {7'd0, tx[0]}, 8'h00);
                                  chk("a_rstmid_dout", dout[0], 8'h00);
    tick();                       chk("a_rstmid_tx2", {7'd0, tx[0]}, 8'h00);
    send(0, CMD_RD_ADDR, 8'h05);
    send(0, CMD_RD_DATA, 8'h00);
    tick();                       chk("a_post_rst_tx", {7'd0, tx[0]}, 8'h01);
                                  chk("a_post_rst_dout", dout[0], 8'hA5);

    // Reset wins over a same-cycle command
    rst = 1'b1; rx[0] = 1'b1; din[0] = {CMD_RD_DATA, 8'h00};
    tick();
    rst = 1'b0; rx[0] = 1'b0;
    tick();                       chk("a_rst_wins_tx", {7'd0, tx[0]}, 8'h00);

    // ---- DUT 1: auto-increment, DEPTH=4 ----
    send(1, CMD_WR_ADDR, 8'h03);
    send(1, CMD_WR_DATA, 8'h11);  chk("b_wd1_err", {7'd0, err[1]}, 8'h00);
    send(1, CMD_WR_DATA, 8'h22);  chk("b_wd2_err", {7'd0, err[1]}, 8'h00);
    send(1, CMD_RD_ADDR, 8'h03);
    rx[1] = 1'b1; din[1] = {CMD_RD_DATA, 8'h00};
    tick();
    tick();                       rx[1] = 1'b0;
                                  chk("b_burst_tx1", {7'd0, tx[1]}, 8'h01);
                                  chk("b_burst_d1", dout[1], 8'h11);
    tick();                       chk("b_burst_tx2", {7'd0, tx[1]}, 8'h01);
                                  chk("b_burst_d2", dout[1], 8'h22);
    tick();                       chk("b_burst_tx3", {7'd0, tx[1]}, 8'h00);

    // Out-of-range write flags an error and wraps the pointer to 0
    send(1, CMD_WR_ADDR, 8'h09);
    send(1, CMD_WR_DATA, 8'h33);  chk("b_oor_err", {7'd0, err[1]}, 8'h01);
    tick();                       chk("b_oor_err_end", {7'd0, err[1]}, 8'h00);
    send(1, CMD_WR_DATA, 8'h44);
    send(1, CMD_RD_ADDR, 8'h00);
    send(1, CMD_RD_DATA, 8'h00);
    tick();                       chk("b_wrap_dout", dout[1], 8'h44);

    // ---- DUT 2: DEPTH=200 boundary ----
    send(2, CMD_WR_ADDR, 8'hC7);
    send(2, CMD_WR_DATA, 8'h99);  chk("c_top_wr_err", {7'd0, err[2]}, 8'h00);
    send(2, CMD_RD_ADDR, 8'hC7);
    send(2, CMD_RD_DATA, 8'h00);  chk("c_top_rd_err", {7'd0, err[2]}, 8'h00);
    tick();                       chk("c_top_dout", dout[2], 8'h99);
    send(2, CMD_WR_ADDR, 8'hFA);
    send(2, CMD_WR_DATA, 8'h77);  chk("c_oor_wr_err", {7'd0, err[2]}, 8'h01);
    tick();                       chk("c_oor_wr_err_end", {7'd0, err[2]}, 8'h00);
    send(2, CMD_RD_ADDR, 8'hFA);
    send(2, CMD_RD_DATA, 8'h00);  chk("c_oor_rd_err", {7'd0, err[2]}, 8'h01);
                                  chk("c_oor_rd_lat", {7'd0, tx[2]}, 8'h00);
    tick();                       chk("c_oor_rd_tx", {7'd0, tx[2]}, 8'h01);
                                  chk("c_oor_rd_dout", dout[2], 8'h00);
                                  chk("c_oor_rd_err_end", {7'd0, err[2]}, 8'h00);
    tick();                       chk("c_oor_rd_tx_end", {7'd0, tx[2]}, 8'h00);
    // In-range data is still intact after the out-of-range accesses
    send(2, CMD_RD_ADDR, 8'hC7);
    send(2, CMD_RD_DATA, 8'h00);
    tick();                       chk("c_top_dout2", dout[2], 8'h99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
